mont_mul_sequencer: RTL and testbench

//  Radix-2 Montgomery multiplication controller sitting directly upstream of mpadder.

---
 rtl/mont_pkg.sv | 17 +
 rtl/mont_operand_shreg.sv | 38 +++
 rtl/mont_mul_sequencer.sv | 147 ++++++++++++++
 tb/tb_mont_mul_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mont_pkg.sv
// Shared definitions for the Montgomery multiplier controller and its adder.
package mont_pkg;

  localparam int WIDTH_DEF = 512;
  localparam int CNT_W_DEF = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD_B = 3'd2,
    ADD_M = 3'd3,
    SUB_M = 3'd4,
    FIX   = 3'd5,
    DONE  = 3'd6
  } mont_state_e;

endpackage

// File: rtl/mont_operand_shreg.sv
// Loadable right-shift register holding multiplier A; bit 0 is the current multiplier bit.
module mont_operand_shreg
  import mont_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             bit0
);

  logic [WIDTH-1:0] data_q, data_d;

  // Load takes priority over shifting.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift_en) begin
      data_d = data_q >> 1;
    end
  end

  // Operand register with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign bit0 = data_q[0];

endmodule

// File: rtl/mont_mul_sequencer.sv
// Radix-2 Montgomery multiplication controller driving the mpadder accumulator.
//
// state | meaning
// IDLE  | waiting for start
// CLEAR | zero the adder accumulator
// ADD_B | accumulate a_i * B
// ADD_M | accumulate q * M and halve, q = accumulator LSB
// SUB_M | trial subtract of M
// FIX   | add M back if the trial subtract went negative
// DONE  | one-cycle completion pulse
module mont_mul_sequencer
  import mont_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic             busy,
  output logic             done,
  output logic [WIDTH+1:0] add_in,
  output logic             add_subtract,
  output logic             add_shift,
  output logic             add_enableC,
  output logic             add_clear,
  input  logic             add_c_lsb,
  input  logic             add_c_neg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mont_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             a_load;
  logic             a_shift;
  logic             a_bit0;

  mont_operand_shreg #(.WIDTH(WIDTH)) u_a_shreg (
    .clk      (clk),
    .reset    (reset),
    .load     (a_load),
    .shift_en (a_shift),
    .din      (in_a),
    .bit0     (a_bit0)
  );

  // Next-state, loop counter and operand capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    m_d     = m_q;
    a_load  = 1'b0;
    a_shift = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          b_d     = in_b;
          m_d     = in_m;
          a_load  = 1'b1;
        end
      end
      CLEAR: state_d = ADD_B;
      ADD_B: state_d = ADD_M;
      ADD_M: begin
        a_shift = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = SUB_M;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ADD_B;
        end
      end
      SUB_M:   state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder control decode from the registered state and adder feedback only.
  always_comb begin
    busy         = 1'b0;
    done         = 1'b0;
    add_in       = '0;
    add_subtract = 1'b0;
    add_shift    = 1'b0;
    add_enableC  = 1'b0;
    add_clear    = 1'b0;
    case (state_q)
      CLEAR: begin
        busy      = 1'b1;
        add_clear = 1'b1;
      end
      ADD_B: begin
        busy        = 1'b1;
        add_enableC = 1'b1;
        add_in      = a_bit0 ? {2'b00, b_q} : '0;
      end
      ADD_M: begin
        busy        = 1'b1;
        add_enableC = 1'b1;
        add_shift   = 1'b1;
        add_in      = add_c_lsb ? {2'b00, m_q} : '0;
      end
      SUB_M: begin
        busy         = 1'b1;
        add_enableC  = 1'b1;
        add_subtract = 1'b1;
        add_in       = {2'b00, m_q};
      end
      FIX: begin
        busy = 1'b1;
        if (add_c_neg) begin
          add_enableC = 1'b1;
          add_in      = {2'b00, m_q};
        end
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // State, counter and latched operands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      m_q     <= m_d;
    end
  end

endmodule

// File: tb/tb_mont_mul_sequencer.sv
// Bench for mont_mul_sequencer: a WIDTH=8 and a WIDTH=512 instance, each closed around a
// behavioural accumulator standing in for mpadder; results are judged with modular arithmetic.
module tb_mont_mul_sequencer;

  localparam int WS = 8;
  localparam int WL = 512;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // small instance
  logic          start_s;
  logic [WS-1:0] a_s, b_s, m_s;
  logic          busy_s, done_s, sub_s, shift_s, en_s, clr_s, lsb_s, neg_s;
  logic [WS+1:0] add_in_s;

  // large instance
  logic          start_l;
  logic [WL-1:0] a_l, b_l, m_l;
  logic          busy_l, done_l, sub_l, shift_l, en_l, clr_l, lsb_l, neg_l;
  logic [WL+1:0] add_in_l;

  mont_mul_sequencer #(.WIDTH(WS), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .in_a(a_s), .in_b(b_s), .in_m(m_s),
    .busy(busy_s), .done(done_s), .add_in(add_in_s), .add_subtract(sub_s),
    .add_shift(shift_s), .add_enableC(en_s), .add_clear(clr_s),
    .add_c_lsb(lsb_s), .add_c_neg(neg_s)
  );

  mont_mul_sequencer #(.WIDTH(WL), .CNT_W(10)) dut_l (
    .clk(clk), .reset(reset), .start(start_l), .in_a(a_l), .in_b(b_l), .in_m(m_l),
    .busy(busy_l), .done(done_l), .add_in(add_in_l), .add_subtract(sub_l),
    .add_shift(shift_l), .add_enableC(en_l), .add_clear(clr_l),
    .add_c_lsb(lsb_l), .add_c_neg(neg_l)
  );

  // ---------------- behavioural mpadder ----------------
  // Add or subtract into a (w+2)-bit accumulator, optional halve; bit 520 returns the borrow.
  function automatic logic [520:0] acc_step(input logic [519:0] acc, input logic [519:0] opnd,
                                            input logic sub, input logic sh, input int w);
    logic [519:0] s, mask;
    logic         ng;
    s    = sub ? acc - opnd : acc + opnd;
    ng   = s[w+2];
    mask = (520'(1) << (w + 2)) - 520'(1);
    s    = s & mask;
    if (sh) s = s >> 1;
    return {ng, s};
  endfunction

  logic [519:0] acc_s = '0, acc_l = '0;
  logic         accneg_s = 1'b0, accneg_l = 1'b0;
  logic [519:0] cin_s, cin_l;
  logic         csub_s, csh_s, cen_s, cclr_s, csub_l, csh_l, cen_l, cclr_l;
  logic [520:0] nxt_s, nxt_l;

  always @(negedge clk) begin
    cin_s <= 520'(add_in_s); csub_s <= sub_s; csh_s <= shift_s; cen_s <= en_s; cclr_s <= clr_s;
    cin_l <= 520'(add_in_l); csub_l <= sub_l; csh_l <= shift_l; cen_l <= en_l; cclr_l <= clr_l;
  end

  assign nxt_s = acc_step(acc_s, cin_s, csub_s, csh_s, WS);
  assign nxt_l = acc_step(acc_l, cin_l, csub_l, csh_l, WL);

  always @(posedge clk) begin
    if (cclr_s) acc_s <= '0;
    else if (cen_s) begin
      acc_s <= nxt_s[519:0];
      if (csub_s) accneg_s <= nxt_s[520];
    end
    if (cclr_l) acc_l <= '0;
    else if (cen_l) begin
      acc_l <= nxt_l[519:0];
      if (csub_l) accneg_l <= nxt_l[520];
    end
  end

  assign lsb_s = acc_s[0];
  assign neg_s = accneg_s;
  assign lsb_l = acc_l[0];
  assign neg_l = accneg_l;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // C is A*B*2^-w mod M exactly when C < M and C*2^w == A*B (mod M).
  task automatic check_mont(input string name, input logic [511:0] a, input logic [511:0] b,
                            input logic [511:0] m, input logic [519:0] c, input int w);
    logic [1023:0] lhs, rhs, mm;
    mm  = 1024'(m);
    lhs = (1024'(c) << w) % mm;
    rhs = (1024'(a) * 1024'(b)) % mm;
    check({name, "_modeq"}, lhs, rhs);
    check({name, "_range"}, 1024'(c < 520'(m)), 1024'(1));
  endtask

  function automatic logic [WL-1:0] rand512();
    logic [WL-1:0] r;
    for (int i = 0; i < WL / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Runs one multiplication on the small instance; returns result, latency, FIX write and
  // whether any loop-phase add_in was nonzero.
  task automatic run_s(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic [WS-1:0] m,
                       input bit toggle, output logic [519:0] c, output int lat,
                       output bit fix_en, output bit loop_nz);
    bit prev_sub;
    @(negedge clk);
    a_s = a; b_s = b; m_s = m; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    lat = 0; fix_en = 0; loop_nz = 0; prev_sub = 0;
    while (!done_s && lat < 200) begin
      if (prev_sub) fix_en = en_s;
      if (en_s && !sub_s && !prev_sub && add_in_s != '0) loop_nz = 1;
      prev_sub = sub_s;
      if (toggle) begin
        a_s = WS'($urandom); b_s = WS'($urandom); m_s = WS'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    c = acc_s;
  endtask

  task automatic run_l(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic [WL-1:0] m,
                       input bit toggle, output logic [519:0] c, output int lat);
    @(negedge clk);
    a_l = a; b_l = b; m_l = m; start_l = 1'b1;
    @(negedge clk);
    start_l = 1'b0;
    lat = 0;
    while (!done_l && lat < 2000) begin
      if (toggle) begin
        a_l = rand512(); b_l = rand512(); m_l = rand512();
      end
      @(negedge clk);
      lat++;
    end
    c = acc_l;
  endtask

  typedef struct {
    logic [7:0] a, b, m;
    logic [9:0] exp_c;
    bit         exp_fix;
  } vec_t;

  vec_t tv[5];

  initial begin
    logic [519:0] c;
    int           lat, dones, done_at;
    bit           fix_en, loop_nz;
    logic [WL-1:0] ra, rb, rm;
    logic [WS-1:0] sa, sb, sm;

    tv[0] = '{a: 8'd5,   b: 8'd7,   m: 8'd13,  exp_c: 10'd1,   exp_fix: 1'b1};
    tv[1] = '{a: 8'd0,   b: 8'd200, m: 8'd251, exp_c: 10'd0,   exp_fix: 1'b1};
    tv[2] = '{a: 8'd7,   b: 8'd5,   m: 8'd13,  exp_c: 10'd1,   exp_fix: 1'b1};
    tv[3] = '{a: 8'd12,  b: 8'd12,  m: 8'd13,  exp_c: 10'd3,   exp_fix: 1'b1};
    tv[4] = '{a: 8'd250, b: 8'd250, m: 8'd251, exp_c: 10'd201, exp_fix: 1'b0};

    reset = 1'b1;
    start_s = 1'b0; a_s = '0; b_s = '0; m_s = '0;
    start_l = 1'b0; a_l = '0; b_l = '0; m_l = '0;
    #12;
    check("reset_outputs_s", 1024'({busy_s, done_s, add_in_s, sub_s, shift_s, en_s, clr_s}), 1024'(0));
    check("reset_outputs_l", 1024'({busy_l, done_l, add_in_l, sub_l, shift_l, en_l, clr_l}), 1024'(0));
    @(negedge clk);
    reset = 1'b0;

    // directed WIDTH=8 table
    for (int i = 0; i < 5; i++) begin
      run_s(tv[i].a, tv[i].b, tv[i].m, 1'b0, c, lat, fix_en, loop_nz);
      check($sformatf("tv%0d_latency", i), 1024'(lat), 1024'(2 * WS + 3));
      check($sformatf("tv%0d_result", i), 1024'(c), 1024'(tv[i].exp_c));
      check($sformatf("tv%0d_fix_enable", i), 1024'(fix_en), 1024'(tv[i].exp_fix));
      if (tv[i].a == 8'd0) check($sformatf("tv%0d_loop_add_in_zero", i), 1024'(loop_nz), 1024'(0));
    end

    // random WIDTH=8 runs, back-to-back
    for (int i = 0; i < 10; i++) begin
      sm = WS'($urandom) | 8'h81;
      sb = WS'($urandom_range(0, int'(sm) - 1));
      sa = WS'($urandom);
      run_s(sa, sb, sm, 1'b0, c, lat, fix_en, loop_nz);
      check($sformatf("rnd8_%0d_latency", i), 1024'(lat), 1024'(2 * WS + 3));
      check_mont($sformatf("rnd8_%0d", i), 512'(sa), 512'(sb), 512'(sm), c, WS);
    end

    // operands toggled every cycle after acceptance
    run_s(8'd5, 8'd7, 8'd13, 1'b1, c, lat, fix_en, loop_nz);
    check("toggle8_result", 1024'(c), 1024'(1));

    // start mid-run (counter 3) and during DONE are both ignored
    @(negedge clk);
    a_s = 8'd5; b_s = 8'd7; m_s = 8'd13; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    dones = 0; done_at = -1;
    for (int n = 0; n < 60; n++) begin
      if (done_s) begin
        dones++;
        if (done_at < 0) begin
          done_at = n;
          check("ignore_result", 1024'(acc_s), 1024'(1));
        end
      end
      if (n == 8) begin a_s = 8'd1; b_s = 8'd1; m_s = 8'd13; end
      start_s = (n == 8) || done_s;
      @(negedge clk);
    end
    start_s = 1'b0;
    check("ignore_done_count", 1024'(dones), 1024'(1));
    check("ignore_done_latency", 1024'(done_at), 1024'(2 * WS + 3));
    check("ignore_idle_after", 1024'(busy_s), 1024'(0));

    // reset during ADD_M with counter 5
    @(negedge clk);
    a_s = 8'd12; b_s = 8'd12; m_s = 8'd13; start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int n = 0; n < 12; n++) @(negedge clk);
    check("pre_reset_in_add_m", 1024'({busy_s, shift_s, en_s}), 1024'(3'b111));
    reset = 1'b1;
    #1;
    check("reset_mid_outputs", 1024'({busy_s, done_s, add_in_s, sub_s, shift_s, en_s, clr_s}), 1024'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      if (done_s || busy_s) dones++;
      @(negedge clk);
    end
    check("reset_no_done", 1024'(dones), 1024'(0));
    run_s(8'd12, 8'd12, 8'd13, 1'b0, c, lat, fix_en, loop_nz);
    check("post_reset_result", 1024'(c), 1024'(3));
    check("post_reset_latency", 1024'(lat), 1024'(2 * WS + 3));

    // WIDTH=512 random runs
    for (int i = 0; i < 20; i++) begin
      rm = rand512();
      rm[WL-1] = 1'b1;
      rm[0] = 1'b1;
      rb = rand512() % rm;
      ra = rand512();
      run_l(ra, rb, rm, (i == 0), c, lat);
      check($sformatf("rnd512_%0d_latency", i), 1024'(lat), 1024'(2 * WL + 3));
      check_mont($sformatf("rnd512_%0d", i), ra, rb, rm, c, WL);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
